bus_lcd_formatter: RTL

Snoops completed transactions on the system bus and renders the most recent one, plus a running transaction count, as 32 ASCII characters for the 16x2 LCD driver directly downstream. The 32 character outputs connect one-to-one to the LCD top's `Line11..Line116` and `Line21..Line216` inputs. Each displayed transaction is held on screen for a programmable dwell time. During the dwell, at most one later transaction is buffered and any further ones are flagged as dropped.

---
 rtl/bus_lcd_formatter.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/bus_lcd_formatter.sv
// bus_lcd_formatter
// Snoops completed bus transactions and renders the latest one, plus a
// running 16-bit transaction count, as two 16-character ASCII rows for the
// downstream 16x2 LCD driver. Each shown transaction dwells HOLD_CYCLES
// clocks; one later transaction may wait in a pending slot, and any further
// ones during the same dwell set a sticky drop marker.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | dwell expired, nothing pending; next txn is shown immediately
// HOLD  | a txn is on screen; hold counter runs down to zero

module bus_lcd_formatter #(
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        txn_valid,
    input  logic [1:0]  txn_master,
    input  logic [1:0]  txn_slave,
    input  logic        txn_write,
    input  logic [11:0] txn_addr,
    input  logic [7:0]  txn_data,
    output logic [7:0]  Line11,
    output logic [7:0]  Line12,
    output logic [7:0]  Line13,
    output logic [7:0]  Line14,
    output logic [7:0]  Line15,
    output logic [7:0]  Line16,
    output logic [7:0]  Line17,
    output logic [7:0]  Line18,
    output logic [7:0]  Line19,
    output logic [7:0]  Line110,
    output logic [7:0]  Line111,
    output logic [7:0]  Line112,
    output logic [7:0]  Line113,
    output logic [7:0]  Line114,
    output logic [7:0]  Line115,
    output logic [7:0]  Line116,
    output logic [7:0]  Line21,
    output logic [7:0]  Line22,
    output logic [7:0]  Line23,
    output logic [7:0]  Line24,
    output logic [7:0]  Line25,
    output logic [7:0]  Line26,
    output logic [7:0]  Line27,
    output logic [7:0]  Line28,
    output logic [7:0]  Line29,
    output logic [7:0]  Line210,
    output logic [7:0]  Line211,
    output logic [7:0]  Line212,
    output logic [7:0]  Line213,
    output logic [7:0]  Line214,
    output logic [7:0]  Line215,
    output logic [7:0]  Line216
);

    // Counter only ever holds HOLD_CYCLES-1; keep at least one bit for HOLD_CYCLES=1.
    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] HOLD_RELOAD = CW'(HOLD_CYCLES - 1);

    localparam logic [127:0] RESET_ROW1 = "NO TRANSACTION  ";
    localparam logic [127:0] RESET_ROW2 = "D:00 N:0000     ";

    typedef enum logic {
        S_IDLE,
        S_HOLD
    } state_t;

    typedef struct packed {
        logic [1:0]  master;
        logic [1:0]  slave;
        logic        write;
        logic [11:0] addr;
        logic [7:0]  data;
    } txn_t;

    state_t          r_state;
    logic [CW-1:0]   r_hold_cnt;
    logic            r_pend;
    txn_t            r_pend_txn;
    txn_t            r_disp_txn;
    logic            r_have_disp;
    logic            r_drop;
    logic [15:0]     r_txn_count;
    logic [127:0]    r_row1;
    logic [127:0]    r_row2;

    txn_t            w_txn_in;
    logic            w_cnt_zero;

    assign w_txn_in   = '{master: txn_master, slave: txn_slave, write: txn_write,
                          addr: txn_addr, data: txn_data};
    assign w_cnt_zero = (r_hold_cnt == '0);

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

    function automatic logic [7:0] index_ascii(input logic [1:0] idx);
        return 8'h31 + {6'h0, idx};
    endfunction

    // Running transaction count: every accepted pulse, shown or not.
    always_ff @(posedge clock) begin
        if (rst) begin
            r_txn_count <= '0;
        end else if (txn_valid) begin
            r_txn_count <= r_txn_count + 16'd1;
        end
    end

    // Display/pending sequencing with dwell timer and sticky drop marker.
    always_ff @(posedge clock) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_hold_cnt  <= '0;
            r_pend      <= 1'b0;
            r_pend_txn  <= '0;
            r_disp_txn  <= '0;
            r_have_disp <= 1'b0;
            r_drop      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (txn_valid) begin
                        r_disp_txn  <= w_txn_in;
                        r_have_disp <= 1'b1;
                        r_hold_cnt  <= HOLD_RELOAD;
                        r_state     <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (!w_cnt_zero) begin
                        r_hold_cnt <= r_hold_cnt - 1'b1;
                        if (txn_valid) begin
                            // Latest wins; overwriting an occupied slot loses a txn.
                            r_pend_txn <= w_txn_in;
                            r_pend     <= 1'b1;
                            if (r_pend) begin
                                r_drop <= 1'b1;
                            end
                        end
                    end else if (r_pend) begin
                        // Promote pending; a txn arriving now takes the freed slot.
                        r_disp_txn <= r_pend_txn;
                        r_hold_cnt <= HOLD_RELOAD;
                        if (txn_valid) begin
                            r_pend_txn <= w_txn_in;
                        end else begin
                            r_pend <= 1'b0;
                        end
                    end else if (txn_valid) begin
                        r_disp_txn <= w_txn_in;
                        r_hold_cnt <= HOLD_RELOAD;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Render the held fields into registered ASCII rows (one cycle behind the fields).
    always_ff @(posedge clock) begin
        if (rst) begin
            r_row1 <= RESET_ROW1;
            r_row2 <= RESET_ROW2;
        end else begin
            if (r_have_disp) begin
                r_row1 <= {"M", index_ascii(r_disp_txn.master),
                           ">S", index_ascii(r_disp_txn.slave),
                           " ", (r_disp_txn.write ? 8'h57 : 8'h52),
                           " A:",
                           hex_ascii(r_disp_txn.addr[11:8]),
                           hex_ascii(r_disp_txn.addr[7:4]),
                           hex_ascii(r_disp_txn.addr[3:0]),
                           "   "};
            end else begin
                r_row1 <= RESET_ROW1;
            end
            r_row2 <= {"D:",
                       hex_ascii(r_disp_txn.data[7:4]),
                       hex_ascii(r_disp_txn.data[3:0]),
                       " N:",
                       hex_ascii(r_txn_count[15:12]),
                       hex_ascii(r_txn_count[11:8]),
                       hex_ascii(r_txn_count[7:4]),
                       hex_ascii(r_txn_count[3:0]),
                       "    ",
                       (r_drop ? 8'h2A : 8'h20)};
        end
    end

    assign Line11  = r_row1[127:120];
    assign Line12  = r_row1[119:112];
    assign Line13  = r_row1[111:104];
    assign Line14  = r_row1[103:96];
    assign Line15  = r_row1[95:88];
    assign Line16  = r_row1[87:80];
    assign Line17  = r_row1[79:72];
    assign Line18  = r_row1[71:64];
    assign Line19  = r_row1[63:56];
    assign Line110 = r_row1[55:48];
    assign Line111 = r_row1[47:40];
    assign Line112 = r_row1[39:32];
    assign Line113 = r_row1[31:24];
    assign Line114 = r_row1[23:16];
    assign Line115 = r_row1[15:8];
    assign Line116 = r_row1[7:0];

    assign Line21  = r_row2[127:120];
    assign Line22  = r_row2[119:112];
    assign Line23  = r_row2[111:104];
    assign Line24  = r_row2[103:96];
    assign Line25  = r_row2[95:88];
    assign Line26  = r_row2[87:80];
    assign Line27  = r_row2[79:72];
    assign Line28  = r_row2[71:64];
    assign Line29  = r_row2[63:56];
    assign Line210 = r_row2[55:48];
    assign Line211 = r_row2[47:40];
    assign Line212 = r_row2[39:32];
    assign Line213 = r_row2[31:24];
    assign Line214 = r_row2[23:16];
    assign Line215 = r_row2[15:8];
    assign Line216 = r_row2[7:0];

endmodule
